// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC stage feeding the word-addressed instruction memory.
// Selects sequential, branch, jump or register-jump targets; run/halt/fault FSM and retire counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned MEM_BYTES         = 4096,
  parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] branch_offset;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] next_pc;
  logic            take_branch;
  logic            misaligned;
  logic            out_of_range;
  logic            self_jump;
  logic            unused_opcode;

  // Opcode field is decoded upstream; only immediate/target fields are consumed here.
  assign unused_opcode = ^instruction[31:26];

  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign take_branch   = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

  // Next-PC priority: jr, then j/jal, then taken branch, else sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (take_branch) begin
      next_pc = branch_target;
    end
  end

  assign misaligned   = (next_pc[1:0] != 2'b00);
  assign out_of_range = (next_pc >= MEM_LIMIT);
  assign self_jump    = HALT_ON_SELF_JUMP && (jump | jump_reg) && (next_pc == pc);

  // State, PC and counter; HALT/FAULT are sticky until reset, stall freezes RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      instr_count <= '0;
      running     <= 1'b1;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            instr_count <= instr_count + 32'd1;
            if (misaligned || out_of_range) begin
              state   <= ST_FAULT;
              running <= 1'b0;
              fault   <= 1'b1;
            end else if (self_jump) begin
              state   <= ST_HALT;
              running <= 1'b0;
              halted  <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        ST_HALT, ST_FAULT: begin
          state <= state;
        end
        default: begin
          state   <= ST_FAULT;
          running <= 1'b0;
          halted  <= 1'b0;
          fault   <= 1'b1;
        end
      endcase
    end
  end

  // Control decode must never combine jr with a conditional branch.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_RUN) begin
      assert (!(jump_reg && (branch_eq || branch_ne)));
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the fetch stage.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instruction;
  logic        branch_eq;
  logic        branch_ne;
  logic        alu_zero;
  logic        jump;
  logic        jump_reg;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        running;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;

  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_FAULT = 2;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_state;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .instruction(instruction),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .jump(jump), .jump_reg(jump_reg), .rs_data(rs_data),
    .pc(pc), .pc_plus4(pc_plus4), .running(running), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: one clock of the fetch stage, computed from the architectural rules.
  task automatic model_step(input logic rst, input logic st, input logic [31:0] ins,
                            input logic beq, input logic bne, input logic z,
                            input logic j, input logic jr, input logic [31:0] rs);
    logic [31:0] np;
    logic [31:0] seq;
    int          off;
    if (rst) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_state = M_RUN;
      return;
    end
    if (m_state != M_RUN || st) return;
    seq = m_pc + 32'd4;
    off = int'($signed(ins[15:0]));
    if (jr)                     np = rs;
    else if (j)                 np = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    else if ((beq && z) || (bne && !z)) np = seq + 32'(off * 4);
    else                        np = seq;
    m_cnt = m_cnt + 32'd1;
    if ((np % 32'd4) != 0 || np >= 32'd4096) m_state = M_FAULT;
    else if ((j || jr) && np == m_pc)       m_state = M_HALT;
    else                                    m_pc = np;
  endtask

  // Apply one cycle of inputs, check the combinational link value, clock, then check state.
  task automatic step(input logic rst, input logic st, input logic [31:0] ins,
                      input logic beq, input logic bne, input logic z,
                      input logic j, input logic jr, input logic [31:0] rs);
    reset = rst; stall = st; instruction = ins; branch_eq = beq; branch_ne = bne;
    alu_zero = z; jump = j; jump_reg = jr; rs_data = rs;
    #1;
    if (!rst) check("pc_plus4", pc_plus4, m_pc + 32'd4);
    model_step(rst, st, ins, beq, bne, z, j, jr, rs);
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("instr_count", instr_count, m_cnt);
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("halted", 32'(halted), 32'(m_state == M_HALT));
    check("fault", 32'(fault), 32'(m_state == M_FAULT));
  endtask

  task automatic seq_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_cnt = 32'h0; m_state = M_RUN;
    reset = 1'b1; stall = 1'b0; instruction = '0; branch_eq = 1'b0; branch_ne = 1'b0;
    alu_zero = 1'b0; jump = 1'b0; jump_reg = 1'b0; rs_data = '0;
    @(posedge clk); #1;

    // Reset and sequential fetch
    do_reset();
    check("reset_pc", pc, 32'h0);
    seq_step(); seq_step(); seq_step();
    check("seq_pc_12", pc, 32'd12);
    check("seq_count_3", instr_count, 32'd3);

    // beq taken / not taken from 0x10
    jr_to(32'h10);
    step(1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("beq_taken", pc, 32'h24);
    jr_to(32'h10);
    step(1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("beq_not_taken", pc, 32'h14);

    // bne with negative offset
    jr_to(32'h20);
    step(1'b0, 1'b0, 32'h0000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("bne_neg", pc, 32'h1C);

    // j and jr
    jr_to(32'h18);
    step(1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("j_target", pc, 32'h20);
    jr_to(32'h3C);
    check("jr_target", pc, 32'h3C);

    // Misaligned jr faults with pc frozen; fault is sticky
    jr_to(32'h1002);
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_pc", pc, 32'h3C);
    jr_to(32'h40);
    check("fault_sticky_pc", pc, 32'h3C);

    // Sequential step off the end of memory
    do_reset();
    jr_to(32'hFFC);
    seq_step();
    check("range_fault", 32'(fault), 32'd1);
    check("range_pc", pc, 32'hFFC);

    // Stall in RUN holds pc and count
    do_reset();
    jr_to(32'h40);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    check("stall_pc", pc, 32'h40);
    check("stall_count", instr_count, 32'd1);

    // Self jump halts; pc held while control inputs toggle
    step(1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("self_jump_halt", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    check("halt_hold_pc", pc, 32'h40);
    do_reset();
    check("reset_from_halt_pc", pc, 32'h0);
    check("reset_from_halt_run", 32'(running), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [31:0] rs;
      logic        use_jr;
      logic        use_br;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[25:10] = 16'h0;
      rs = {20'h0, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 2) != 0) rs[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rs = m_pc;
      use_jr = ($urandom_range(0, 5) == 0);
      use_br = !use_jr && ($urandom_range(0, 2) == 0);
      if (m_state != M_RUN && $urandom_range(0, 2) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 60) == 0, $urandom_range(0, 7) == 0, ins,
             use_br && $urandom_range(0, 1) == 1, use_br && $urandom_range(0, 1) == 1,
             1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, use_jr, rs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
